// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit core board logic.
//   run_state_t  : run controller state encoding (HALT/RUN/STEP/CRST)
//   DEF_*        : default divider, core-reset length and prescaler width
package cpu16_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_CRST = 2'd3
  } run_state_t;

  localparam int DEF_SLOW_DIV = 4194304;
  localparam int DEF_FAST_DIV = 262144;
  localparam int DEF_RST_CYC  = 4;
  localparam int DEF_DIV_W    = 23;

endpackage

// File: rtl/run_tick_div.sv
// Prescaler that paces core_en pulses while the core is running.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   clr   : clears the count and any pending tick (wins over en)
//   en    : count this cycle
//   limit : pulse period in clk cycles
//   tick  : registered one-cycle pulse, one cycle after the count wraps
module run_tick_div
  import cpu16_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] limit,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic             wrap;

  // >= rather than == so that lowering the limit mid-count still wraps
  // on the very next cycle instead of running all the way around.
  assign wrap = (cnt_q >= (limit - DIV_W'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (clr) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (en) begin
      if (wrap) begin
        cnt_q <= '0;
        tick  <= 1'b1;
      end else begin
        cnt_q <= cnt_q + DIV_W'(1);
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Run/halt/step/reset sequencer for the 16-bit core on a single fast clock.
// The core advances only on cycles where core_en is high.
// Ports:
//   clk, reset (async, active-low)
//   btn_run   : rising edge toggles RUN/HALT
//   btn_step  : rising edge executes one core cycle while halted
//   btn_crst  : rising edge starts a timed core reset
//   fast      : selects FAST_DIV (1) or SLOW_DIV (0) pacing in RUN
//   halt_req  : HLT instruction from the core, forces HALT
//   core_en   : one-cycle core clock enable
//   core_rst  : synchronous active-high core reset, RST_CYC cycles long
//   running   : high while in RUN
//   cycles    : core_en pulses since reset or the last core reset
module core_run_ctrl
  import cpu16_pkg::*;
#(
  parameter int SLOW_DIV = DEF_SLOW_DIV,
  parameter int FAST_DIV = DEF_FAST_DIV,
  parameter int RST_CYC  = DEF_RST_CYC,
  parameter int DIV_W    = DEF_DIV_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        btn_crst,
  input  logic        fast,
  input  logic        halt_req,
  output logic        core_en,
  output logic        core_rst,
  output logic        running,
  output logic [15:0] cycles
);

  localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  run_state_t       state_q, state_d;
  logic             run_prev, step_prev, crst_prev;
  logic             run_edge, step_edge, crst_edge;
  logic [RC_W-1:0]  rcnt_q;
  logic             crst_done;
  logic             step_q, step_d, core_rst_d, running_d;
  logic             div_clr, div_en, tick;
  logic [DIV_W-1:0] limit;
  logic [15:0]      cyc_q;

  assign run_edge  = btn_run  & ~run_prev;
  assign step_edge = btn_step & ~step_prev;
  assign crst_edge = btn_crst & ~crst_prev;
  assign crst_done = (rcnt_q == RC_W'(RST_CYC - 1));
  assign limit     = fast ? DIV_W'(FAST_DIV) : DIV_W'(SLOW_DIV);
  // The two sources are mutually exclusive: tick only exists in RUN,
  // step_q only in the single STEP cycle.
  assign core_en   = tick | step_q;
  assign cycles    = cyc_q;

  // Previous levels reset high so a button held through reset is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_prev  <= 1'b1;
      step_prev <= 1'b1;
      crst_prev <= 1'b1;
    end else begin
      run_prev  <= btn_run;
      step_prev <= btn_step;
      crst_prev <= btn_crst;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_HALT;
    else        state_q <= state_d;
  end

  // Priority: crst edge, then halt_req, then run edge, then step edge.
  always_comb begin
    state_d = state_q;
    if (crst_edge) begin
      state_d = ST_CRST;
    end else begin
      case (state_q)
        ST_HALT: begin
          if (run_edge && !halt_req) state_d = ST_RUN;
          else if (step_edge)        state_d = ST_STEP;
        end
        ST_RUN:  if (halt_req || run_edge) state_d = ST_HALT;
        ST_STEP: state_d = ST_HALT;
        ST_CRST: if (crst_done) state_d = ST_HALT;
        default: state_d = ST_HALT;
      endcase
    end
  end

  // Prescaler is held clear outside RUN and on the cycle RUN is left, so a
  // tick falling on the halt cycle never reaches core_en.
  always_comb begin
    step_d     = (state_d == ST_STEP);
    core_rst_d = (state_d == ST_CRST);
    running_d  = (state_d == ST_RUN);
    div_clr    = (state_q != ST_RUN) || (state_d != ST_RUN);
    div_en     = (state_q == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q   <= 1'b0;
      core_rst <= 1'b0;
      running  <= 1'b0;
      rcnt_q   <= '0;
      cyc_q    <= '0;
    end else begin
      step_q   <= step_d;
      core_rst <= core_rst_d;
      running  <= running_d;
      if (crst_edge)              rcnt_q <= '0;
      else if (state_q == ST_CRST) rcnt_q <= rcnt_q + RC_W'(1);
      if (crst_edge)    cyc_q <= '0;
      else if (core_en) cyc_q <= cyc_q + 16'd1;
    end
  end

  run_tick_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .clr   (div_clr),
    .en    (div_en),
    .limit (limit),
    .tick  (tick)
  );

endmodule

// File: tb/tb_core_run_ctrl.sv
module tb_core_run_ctrl;

  localparam int SLOW_DIV = 8;
  localparam int FAST_DIV = 2;
  localparam int RST_CYC  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_run = 1'b1;
  logic        btn_step = 1'b0;
  logic        btn_crst = 1'b0;
  logic        fast = 1'b0;
  logic        halt_req = 1'b0;
  logic        core_en;
  logic        core_rst;
  logic        running;
  logic [15:0] cycles;

  int vectors = 0;
  int miscompares = 0;

  logic        preload = 1'b0;
  logic [15:0] preload_val = 16'h0000;

  always #5 clk = ~clk;

  core_run_ctrl #(
    .SLOW_DIV (SLOW_DIV),
    .FAST_DIV (FAST_DIV),
    .RST_CYC  (RST_CYC),
    .DIV_W    (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_run  (btn_run),
    .btn_step (btn_step),
    .btn_crst (btn_crst),
    .fast     (fast),
    .halt_req (halt_req),
    .core_en  (core_en),
    .core_rst (core_rst),
    .running  (running),
    .cycles   (cycles)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model. mode: 0 halt, 1 run, 2 step, 3 core reset.
  // elapsed = cycles spent in RUN since entry or the last pulse;
  // left = core-reset cycles still to be issued.
  int          m_mode = 0;
  int          m_elapsed = 0;
  int          m_left = 0;
  bit          m_en = 0, m_rst = 0, m_running = 0;
  logic [15:0] m_cyc = 16'h0000;
  bit          m_prun = 1, m_pstep = 1, m_pcrst = 1;
  bit          er, es, ec, fire;
  int          lim;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_elapsed = 0; m_left = 0;
      m_en = 0; m_rst = 0; m_running = 0; m_cyc = 16'h0000;
      m_prun = 1; m_pstep = 1; m_pcrst = 1;
    end else begin
      er = btn_run && !m_prun;
      es = btn_step && !m_pstep;
      ec = btn_crst && !m_pcrst;
      m_prun = btn_run; m_pstep = btn_step; m_pcrst = btn_crst;
      lim = fast ? FAST_DIV : SLOW_DIV;
      fire = 0;
      if (preload)   m_cyc = preload_val;
      else if (ec)   m_cyc = 16'h0000;
      else if (m_en) m_cyc = m_cyc + 16'd1;
      if (ec) begin
        m_mode = 3;
        m_left = RST_CYC;
      end else begin
        case (m_mode)
          0: begin
            if (er && !halt_req) begin m_mode = 1; m_elapsed = 0; end
            else if (es) m_mode = 2;
          end
          1: begin
            if (halt_req || er) m_mode = 0;
            else if (m_elapsed >= lim - 1) begin fire = 1; m_elapsed = 0; end
            else m_elapsed++;
          end
          2: m_mode = 0;
          default: begin
            m_left--;
            if (m_left == 0) m_mode = 0;
          end
        endcase
      end
      m_en      = fire || (m_mode == 2);
      m_rst     = (m_mode == 3);
      m_running = (m_mode == 1);
    end
  end

  always @(negedge clk) begin
    check("cmp_core_en", core_en, m_en);
    check("cmp_core_rst", core_rst, m_rst);
    check("cmp_running", running, m_running);
    check("cmp_cycles", cycles, m_cyc);
  end

  task automatic do_preload(input logic [15:0] v);
    @(negedge clk);
    #1;
    preload_val = v;
    preload = 1'b1;
    force dut.cyc_q = preload_val;
    @(posedge clk);
    #1;
    release dut.cyc_q;
    preload = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    // Reset with btn_run already held high.
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_core_en", core_en, 1'b0);
    check("rst_core_rst", core_rst, 1'b0);
    check("rst_running", running, 1'b0);
    check("rst_cycles", cycles, 16'h0000);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("held_run_running", running, 1'b0);
      check("held_run_core_en", core_en, 1'b0);
    end
    btn_run = 1'b0;
    @(negedge clk);

    // Slow RUN: pulses 8, 16, 24 cycles after entry.
    btn_run = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) btn_run = 1'b0;
      check("run_pulse", core_en, (k == 9 || k == 17 || k == 25));
      check("run_running", running, 1'b1);
    end
    @(negedge clk);
    check("run_cycles", cycles, 16'd3);
    btn_run = 1'b1;
    @(negedge clk);
    btn_run = 1'b0;
    check("run_toggle_off", running, 1'b0);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (core_en) pulses++;
    end
    check("halt_no_pulse", pulses, 0);

    // Three single steps from HALT.
    for (int s = 0; s < 3; s++) begin
      btn_step = 1'b1;
      @(negedge clk);
      btn_step = 1'b0;
      check("step_pulse", core_en, 1'b1);
      @(negedge clk);
      check("step_single", core_en, 1'b0);
      @(negedge clk);
    end
    check("step_cycles", cycles, 16'd6);

    // RUN, step ignored, fast switched when prescaler is 5.
    btn_run = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) btn_run = 1'b0;
      if (k == 3) btn_step = 1'b1;
      if (k == 4) btn_step = 1'b0;
      if (k == 6) fast = 1'b1;
      check("fast_pulse", core_en, (k >= 7 && (k % 2) == 1));
    end
    halt_req = 1'b1;
    @(negedge clk);
    check("hreq_running", running, 1'b0);
    check("hreq_core_en", core_en, 1'b0);
    btn_run = 1'b1;
    @(negedge clk);
    btn_run = 1'b0;
    check("hreq_run_ignored", running, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hreq_stay_running", running, 1'b0);
      check("hreq_stay_core_en", core_en, 1'b0);
    end
    halt_req = 1'b0;
    fast = 1'b0;
    @(negedge clk);
    btn_step = 1'b1;
    @(negedge clk);
    btn_step = 1'b0;
    check("hreq_step_pulse", core_en, 1'b1);
    @(negedge clk);
    check("hreq_step_single", core_en, 1'b0);

    // Core reset beats a simultaneous run edge.
    do_preload(16'h0005);
    check("crst_preload", cycles, 16'h0005);
    btn_crst = 1'b1;
    btn_run = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin btn_crst = 1'b0; btn_run = 1'b0; end
      check("crst_core_rst", core_rst, (k <= 4));
      check("crst_running", running, 1'b0);
      check("crst_core_en", core_en, 1'b0);
      if (k == 1) check("crst_cycles_clr", cycles, 16'h0000);
    end
    btn_step = 1'b1;
    @(negedge clk);
    btn_step = 1'b0;
    check("post_crst_step", core_en, 1'b1);
    @(negedge clk);
    check("post_crst_cycles", cycles, 16'd1);

    // A second crst edge restarts the reset count.
    btn_crst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) btn_crst = 1'b0;
      if (k == 2) btn_crst = 1'b1;
      if (k == 3) btn_crst = 1'b0;
      check("crst_restart", core_rst, (k <= 6));
    end

    // Counter wrap.
    do_preload(16'hFFFF);
    check("wrap_preload", cycles, 16'hFFFF);
    btn_step = 1'b1;
    @(negedge clk);
    btn_step = 1'b0;
    check("wrap_step", core_en, 1'b1);
    @(negedge clk);
    check("wrap_cycles", cycles, 16'h0000);

    // Asynchronous reset in the middle of a fast run.
    fast = 1'b1;
    btn_run = 1'b1;
    @(negedge clk);
    btn_run = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("areset_core_en", core_en, 1'b0);
    check("areset_core_rst", core_rst, 1'b0);
    check("areset_running", running, 1'b0);
    check("areset_cycles", cycles, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("areset_after", core_en, 1'b0);
    end
    fast = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
